// File: rtl/upum_pkg.sv
// Shared definitions for the host command router and the per-slave register banks:
// frame start bytes, router FSM state encodings and the slave channel indices.
package upum_pkg;

    localparam logic [7:0] RX_SOF_DEF = 8'hA5;
    localparam logic [7:0] TX_SOF_DEF = 8'h5A;

    // Command parser states
    localparam int unsigned RSW = 2;
    localparam logic [RSW-1:0] R_IDLE = 2'd0;
    localparam logic [RSW-1:0] R_ADDR = 2'd1;
    localparam logic [RSW-1:0] R_LEN  = 2'd2;
    localparam logic [RSW-1:0] R_DATA = 2'd3;

    // Reply framer states
    localparam int unsigned TSW = 3;
    localparam logic [TSW-1:0] T_IDLE = 3'd0;
    localparam logic [TSW-1:0] T_SOF  = 3'd1;
    localparam logic [TSW-1:0] T_IDX  = 3'd2;
    localparam logic [TSW-1:0] T_LEN  = 3'd3;
    localparam logic [TSW-1:0] T_DATA = 3'd4;
    localparam logic [TSW-1:0] T_WAIT = 3'd5;

    // Slave channel indices used by the register banks
    localparam int unsigned REG_RST_POWER = 4;
    localparam int unsigned GPIO_Z        = 26;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/reply_framer.sv
// Reply side of the router: picks the lowest pending slave, frames its reply
// (TX_SOF, idx, len, data) to the host transmitter and pops each byte with rdreq.
module reply_framer
    import upum_pkg::*;
#(
    parameter int unsigned N      = 27,
    parameter int unsigned AW     = 5,
    parameter logic [7:0]  TX_SOF = TX_SOF_DEF
) (
    input  logic           clk,
    input  logic           n_rst,
    input  logic [N-1:0]   have_msg_bus,
    input  logic [N*8-1:0] slave_data_bus,
    input  logic [N*8-1:0] len_bus,
    input  logic           tx_ready,
    output logic [7:0]     tx_data,
    output logic           tx_valid,
    output logic [N-1:0]   rdreq_bus,
    output logic           busy_nxt_c
);

    logic [TSW-1:0] t_state;
    logic [TSW-1:0] t_state_nxt;
    logic [AW-1:0]  idx;
    logic [AW-1:0]  idx_nxt;
    logic [AW-1:0]  pick;
    logic [7:0]     tlen;
    logic [7:0]     tlen_nxt;
    logic [7:0]     txd_q;
    logic [7:0]     txd_nxt;
    logic [7:0]     pick_len;
    logic [7:0]     cur_byte;
    logic           txv_nxt;
    logic           hs;
    logic           pop;

    // Lowest-numbered pending slave wins
    always_comb begin
        pick = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (have_msg_bus[i]) begin
                pick = AW'(i);
            end
        end
    end

    assign pick_len = len_bus[32'(pick) * 8 +: 8];
    assign cur_byte = slave_data_bus[32'(idx) * 8 +: 8];

    assign hs  = tx_valid && tx_ready;
    assign pop = hs && ((t_state == T_DATA) || ((t_state == T_LEN) && (tlen == 8'd0)));

    // Data bytes come straight from the slave; the pop lands in the handshake cycle
    assign rdreq_bus = pop ? (N'(1) << idx) : '0;
    assign tx_data   = (t_state == T_DATA) ? cur_byte : txd_q;

    always_comb begin
        t_state_nxt = t_state;
        idx_nxt     = idx;
        tlen_nxt    = tlen;
        txv_nxt     = 1'b0;
        txd_nxt     = txd_q;

        case (t_state)
            T_IDLE: begin
                if (|have_msg_bus) begin
                    idx_nxt     = pick;
                    tlen_nxt    = pick_len;
                    t_state_nxt = T_SOF;
                end
            end
            T_SOF: begin
                if (hs) t_state_nxt = T_IDX;
            end
            T_IDX: begin
                if (hs) t_state_nxt = T_LEN;
            end
            T_LEN: begin
                if (hs) t_state_nxt = (tlen == 8'd0) ? T_WAIT : T_DATA;
            end
            T_DATA: begin
                if (hs) begin
                    tlen_nxt    = tlen - 8'd1;
                    t_state_nxt = T_WAIT;
                end
            end
            T_WAIT: begin
                // Gives the slave a cycle to advance its byte and have_msg
                t_state_nxt = (tlen != 8'd0) ? T_DATA : T_IDLE;
            end
            default: t_state_nxt = T_IDLE;
        endcase

        case (t_state_nxt)
            T_SOF:   begin txv_nxt = 1'b1; txd_nxt = TX_SOF;      end
            T_IDX:   begin txv_nxt = 1'b1; txd_nxt = 8'(idx_nxt); end
            T_LEN:   begin txv_nxt = 1'b1; txd_nxt = tlen_nxt;    end
            T_DATA:  begin txv_nxt = 1'b1;                        end
            default: begin txv_nxt = 1'b0;                        end
        endcase
    end

    assign busy_nxt_c = (t_state_nxt != T_IDLE);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            t_state  <= T_IDLE;
            idx      <= '0;
            tlen     <= '0;
            txd_q    <= '0;
            tx_valid <= 1'b0;
        end else begin
            t_state  <= t_state_nxt;
            idx      <= idx_nxt;
            tlen     <= tlen_nxt;
            txd_q    <= txd_nxt;
            tx_valid <= txv_nxt;
        end
    end

endmodule

// File: rtl/cmd_router.sv
// Host-side master of the per-slave byte bus: parses command frames into slave write
// strobes and returns slave replies via reply_framer. Optional: CMD_ROUTER_RX_TIMEOUT_EN.
module cmd_router
    import upum_pkg::*;
#(
    parameter int unsigned N         = 27,
    parameter logic [7:0]  RX_SOF    = RX_SOF_DEF,
    parameter logic [7:0]  TX_SOF    = TX_SOF_DEF,
    parameter int unsigned TO_CYCLES = 100000
) (
    input  logic           clk,
    input  logic           n_rst,
    input  logic [7:0]     rx_data,
    input  logic           rx_valid,
    output logic [7:0]     tx_data,
    output logic           tx_valid,
    input  logic           tx_ready,
    output logic [7:0]     master_data,
    output logic [N-1:0]   valid_bus,
    output logic [N-1:0]   rdreq_bus,
    input  logic [N-1:0]   have_msg_bus,
    input  logic [N*8-1:0] slave_data_bus,
    input  logic [N*8-1:0] len_bus,
    output logic [7:0]     err_cnt,
    output logic           busy
);

    localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;

    logic [RSW-1:0] r_state;
    logic [RSW-1:0] r_state_nxt;
    logic [AW-1:0]  addr;
    logic [AW-1:0]  addr_nxt;
    logic           bad;
    logic           bad_nxt;
    logic [7:0]     cnt;
    logic [7:0]     cnt_nxt;
    logic [7:0]     md_nxt;
    logic [N-1:0]   vb_nxt;
    logic           err_inc;
    logic           tx_busy_nxt_c;
    logic           to_hit;

`ifdef CMD_ROUTER_RX_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TO_CYCLES + 1);

    logic [TW-1:0] to_cnt;

    // Inter-byte watchdog; only runs while a frame is open
    assign to_hit = (r_state != R_IDLE) && !rx_valid && (to_cnt == TW'(TO_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            to_cnt <= '0;
        end else if (rx_valid || (r_state == R_IDLE) || to_hit) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TW'(1);
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        r_state_nxt = r_state;
        addr_nxt    = addr;
        bad_nxt     = bad;
        cnt_nxt     = cnt;
        md_nxt      = master_data;
        vb_nxt      = '0;
        err_inc     = 1'b0;

        if (rx_valid) begin
            case (r_state)
                R_IDLE: begin
                    if (rx_data == RX_SOF) r_state_nxt = R_ADDR;
                end
                R_ADDR: begin
                    addr_nxt    = AW'(rx_data);
                    bad_nxt     = (32'(rx_data) >= N);
                    r_state_nxt = R_LEN;
                end
                R_LEN: begin
                    cnt_nxt = rx_data;
                    if (rx_data == 8'd0) begin
                        r_state_nxt = R_IDLE;
                        err_inc     = bad;
                    end else begin
                        r_state_nxt = R_DATA;
                    end
                end
                R_DATA: begin
                    // Bad-address payload is swallowed; the drop is counted at frame end
                    if (!bad) begin
                        md_nxt = rx_data;
                        vb_nxt = N'(1) << addr;
                    end
                    cnt_nxt = cnt - 8'd1;
                    if (cnt == 8'd1) begin
                        r_state_nxt = R_IDLE;
                        err_inc     = bad;
                    end
                end
                default: r_state_nxt = R_IDLE;
            endcase
        end

        if (to_hit) begin
            r_state_nxt = R_IDLE;
            err_inc     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state     <= R_IDLE;
            addr        <= '0;
            bad         <= 1'b0;
            cnt         <= '0;
            master_data <= '0;
            valid_bus   <= '0;
            err_cnt     <= '0;
            busy        <= 1'b0;
        end else begin
            r_state     <= r_state_nxt;
            addr        <= addr_nxt;
            bad         <= bad_nxt;
            cnt         <= cnt_nxt;
            master_data <= md_nxt;
            valid_bus   <= vb_nxt;
            err_cnt     <= err_inc ? sat_inc8(err_cnt) : err_cnt;
            busy        <= (r_state_nxt != R_IDLE) || tx_busy_nxt_c;
        end
    end

    reply_framer #(
        .N      (N),
        .AW     (AW),
        .TX_SOF (TX_SOF)
    ) u_reply_framer (
        .clk            (clk),
        .n_rst          (n_rst),
        .have_msg_bus   (have_msg_bus),
        .slave_data_bus (slave_data_bus),
        .len_bus        (len_bus),
        .tx_ready       (tx_ready),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .rdreq_bus      (rdreq_bus),
        .busy_nxt_c     (tx_busy_nxt_c)
    );

endmodule

// File: tb/tb_cmd_router.sv
// Directed bench for cmd_router: table-driven write-path vectors plus reply-path
// sequences against a small behavioural slave model.
`timescale 1ns/1ps
module tb_cmd_router;

    localparam int unsigned N = 27;

    logic           clk = 1'b0;
    logic           n_rst;
    logic [7:0]     rx_data;
    logic           rx_valid;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_ready;
    logic [7:0]     master_data;
    logic [N-1:0]   valid_bus;
    logic [N-1:0]   rdreq_bus;
    logic [N-1:0]   have_msg_bus;
    logic [N*8-1:0] slave_data_bus;
    logic [N*8-1:0] len_bus;
    logic [7:0]     err_cnt;
    logic           busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cmd_router #(.N(N), .TO_CYCLES(50)) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .master_data    (master_data),
        .valid_bus      (valid_bus),
        .rdreq_bus      (rdreq_bus),
        .have_msg_bus   (have_msg_bus),
        .slave_data_bus (slave_data_bus),
        .len_bus        (len_bus),
        .err_cnt        (err_cnt),
        .busy           (busy)
    );

    // Behavioural slaves: each holds up to 4 reply bytes and pops one per rdreq
    logic [7:0]   smem [N][4];
    logic [7:0]   slen [N];
    int unsigned  spos [N];
    logic [N-1:0] spend = '0;
    logic [N-1:0] ld    = '0;

    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            slave_data_bus[i*8 +: 8] = smem[i][spos[i][1:0]];
            len_bus[i*8 +: 8]        = slen[i];
        end
    end
    assign have_msg_bus = spend;

    always @(posedge clk) begin
        for (int i = 0; i < int'(N); i++) begin
            if (ld[i]) begin
                spos[i]  <= 0;
                spend[i] <= 1'b1;
            end else if (rdreq_bus[i]) begin
                spos[i] <= spos[i] + 1;
                if (spos[i] + 1 >= 32'(slen[i])) spend[i] <= 1'b0;
            end
        end
    end

    // Reply-stream recorder and protocol watchers
    logic [7:0]   got_b [$];
    logic [N-1:0] got_r [$];
    int   stall_err = 0;
    int   stray     = 0;
    int   multi     = 0;
    logic hold_v    = 1'b0;
    logic [7:0] hold_d = 8'h00;

    always @(negedge clk) begin
        if (n_rst === 1'b1) begin
            if (tx_valid && tx_ready) begin
                got_b.push_back(tx_data);
                got_r.push_back(rdreq_bus);
            end else if (rdreq_bus != '0) begin
                stray++;
            end
            if (hold_v && (!tx_valid || tx_data != hold_d)) stall_err++;
            hold_v = tx_valid && !tx_ready;
            hold_d = tx_data;
            if ($countones(rdreq_bus) > 1 || $countones(valid_bus) > 1) multi++;
            for (int i = 0; i < int'(N); i++) begin
                if (rdreq_bus[i] && !spend[i]) stray++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [7:0] d, input logic v);
        rx_data  = d;
        rx_valid = v;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    typedef struct {
        logic       rst;
        logic [7:0] d;
        logic       v;
        int         vb_idx;
        logic [7:0] md;
        logic [7:0] err;
        logic       busy;
    } vec_t;

    function automatic vec_t vr(input logic r, input logic [7:0] d, input logic v,
                                input int vi, input logic [7:0] md, input logic [7:0] e,
                                input logic b);
        vec_t t;
        t.rst = r; t.d = d; t.v = v; t.vb_idx = vi; t.md = md; t.err = e; t.busy = b;
        return t;
    endfunction

    vec_t vecs [$];

    task automatic tx_expect(input string tag, input int base,
                             input logic [7:0] eb [8], input logic [N-1:0] er [8]);
        chk({tag, "_count"}, 32'(got_b.size() - base), 32'd8);
        for (int j = 0; j < 8 && base + j < got_b.size(); j++) begin
            chk($sformatf("%s_byte%0d", tag, j), 32'(got_b[base+j]), 32'(eb[j]));
            chk($sformatf("%s_rdreq%0d", tag, j), 32'(got_r[base+j]), 32'(er[j]));
        end
    endtask

    initial begin
        logic [N-1:0] exp_vb;
        logic [7:0]   eb [8];
        logic [N-1:0] er [8];
        int           base;

        for (int i = 0; i < int'(N); i++) begin
            slen[i] = 8'd0;
            for (int j = 0; j < 4; j++) smem[i][j] = 8'd0;
        end
        n_rst    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // rst, byte, valid, strobe index (-1 none), master_data, err_cnt, busy
        vecs.push_back(vr(0, 8'h00, 0, -1, 8'h00, 8'd0, 0));
        vecs.push_back(vr(1, 8'h00, 0, -1, 8'h00, 8'd0, 0));
        vecs.push_back(vr(1, 8'hA5, 0, -1, 8'h00, 8'd0, 0));
        vecs.push_back(vr(1, 8'hA5, 1, -1, 8'h00, 8'd0, 1));
        vecs.push_back(vr(1, 8'h04, 1, -1, 8'h00, 8'd0, 1));
        vecs.push_back(vr(1, 8'h01, 1, -1, 8'h00, 8'd0, 1));
        vecs.push_back(vr(1, 8'h01, 1,  4, 8'h01, 8'd0, 0));
        vecs.push_back(vr(1, 8'h00, 0, -1, 8'h01, 8'd0, 0));
        vecs.push_back(vr(1, 8'hA5, 1, -1, 8'h01, 8'd0, 1));
        vecs.push_back(vr(1, 8'h0B, 1, -1, 8'h01, 8'd0, 1));
        vecs.push_back(vr(1, 8'h03, 1, -1, 8'h01, 8'd0, 1));
        vecs.push_back(vr(1, 8'h11, 1, 11, 8'h11, 8'd0, 1));
        vecs.push_back(vr(1, 8'h22, 1, 11, 8'h22, 8'd0, 1));
        vecs.push_back(vr(1, 8'h00, 0, -1, 8'h22, 8'd0, 1));
        vecs.push_back(vr(1, 8'h33, 1, 11, 8'h33, 8'd0, 0));
        vecs.push_back(vr(1, 8'h00, 0, -1, 8'h33, 8'd0, 0));
        vecs.push_back(vr(1, 8'hA5, 1, -1, 8'h33, 8'd0, 1));
        vecs.push_back(vr(1, 8'h40, 1, -1, 8'h33, 8'd0, 1));
        vecs.push_back(vr(1, 8'h02, 1, -1, 8'h33, 8'd0, 1));
        vecs.push_back(vr(1, 8'hAA, 1, -1, 8'h33, 8'd0, 1));
        vecs.push_back(vr(1, 8'hBB, 1, -1, 8'h33, 8'd1, 0));
        vecs.push_back(vr(1, 8'hA5, 1, -1, 8'h33, 8'd1, 1));
        vecs.push_back(vr(1, 8'h1A, 1, -1, 8'h33, 8'd1, 1));
        vecs.push_back(vr(1, 8'h01, 1, -1, 8'h33, 8'd1, 1));
        vecs.push_back(vr(1, 8'h7E, 1, 26, 8'h7E, 8'd1, 0));
        vecs.push_back(vr(1, 8'hA5, 1, -1, 8'h7E, 8'd1, 1));
        vecs.push_back(vr(1, 8'h1B, 1, -1, 8'h7E, 8'd1, 1));
        vecs.push_back(vr(1, 8'h00, 1, -1, 8'h7E, 8'd2, 0));
        vecs.push_back(vr(1, 8'hA5, 1, -1, 8'h7E, 8'd2, 1));
        vecs.push_back(vr(1, 8'h03, 1, -1, 8'h7E, 8'd2, 1));
        vecs.push_back(vr(1, 8'h00, 1, -1, 8'h7E, 8'd2, 0));
        vecs.push_back(vr(1, 8'h00, 1, -1, 8'h7E, 8'd2, 0));
        vecs.push_back(vr(1, 8'hFF, 1, -1, 8'h7E, 8'd2, 0));
        vecs.push_back(vr(1, 8'hA5, 1, -1, 8'h7E, 8'd2, 1));
        vecs.push_back(vr(1, 8'h05, 1, -1, 8'h7E, 8'd2, 1));
        vecs.push_back(vr(1, 8'h02, 1, -1, 8'h7E, 8'd2, 1));
        vecs.push_back(vr(1, 8'hA5, 1,  5, 8'hA5, 8'd2, 1));
        vecs.push_back(vr(1, 8'hA5, 1,  5, 8'hA5, 8'd2, 0));
        vecs.push_back(vr(1, 8'hA5, 1, -1, 8'hA5, 8'd2, 1));
        vecs.push_back(vr(1, 8'h05, 1, -1, 8'hA5, 8'd2, 1));
        vecs.push_back(vr(0, 8'h00, 0, -1, 8'h00, 8'd0, 0));
        vecs.push_back(vr(1, 8'h00, 1, -1, 8'h00, 8'd0, 0));
        vecs.push_back(vr(1, 8'hFF, 1, -1, 8'h00, 8'd0, 0));
        vecs.push_back(vr(1, 8'hA5, 1, -1, 8'h00, 8'd0, 1));
        vecs.push_back(vr(1, 8'h05, 1, -1, 8'h00, 8'd0, 1));
        vecs.push_back(vr(1, 8'h01, 1, -1, 8'h00, 8'd0, 1));
        vecs.push_back(vr(1, 8'h01, 1,  5, 8'h01, 8'd0, 0));
        vecs.push_back(vr(1, 8'h00, 0, -1, 8'h01, 8'd0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            n_rst = vecs[i].rst;
            step(vecs[i].d, vecs[i].v);
            exp_vb = (vecs[i].vb_idx < 0) ? '0 : (N'(1) << vecs[i].vb_idx);
            chk($sformatf("vec%0d_valid_bus", i),   32'(valid_bus),   32'(exp_vb));
            chk($sformatf("vec%0d_master_data", i), 32'(master_data), 32'(vecs[i].md));
            chk($sformatf("vec%0d_err_cnt", i),     32'(err_cnt),     32'(vecs[i].err));
            chk($sformatf("vec%0d_busy", i),        32'(busy),        32'(vecs[i].busy));
            if (!vecs[i].rst) begin
                chk($sformatf("vec%0d_tx_valid", i), 32'(tx_valid),  32'd0);
                chk($sformatf("vec%0d_tx_data", i),  32'(tx_data),   32'd0);
                chk($sformatf("vec%0d_rdreq", i),    32'(rdreq_bus), 32'd0);
            end
        end
        n_rst = 1'b1;

`ifdef CMD_ROUTER_RX_TIMEOUT_EN
        step(8'hA5, 1'b1);
        step(8'h06, 1'b1);
        for (int k = 0; k < 49; k++) step(8'h00, 1'b0);
        chk("to_busy_before", 32'(busy), 32'd1);
        step(8'h00, 1'b0);
        chk("to_busy_after", 32'(busy), 32'd0);
        chk("to_err", 32'(err_cnt), 32'd1);
        step(8'hA5, 1'b1);
        step(8'h07, 1'b1);
        step(8'h01, 1'b1);
        step(8'h44, 1'b1);
        chk("to_next_vb", 32'(valid_bus), 32'(N'(1) << 7));
        chk("to_next_md", 32'(master_data), 32'h44);
`else
        step(8'hA5, 1'b1);
        step(8'h06, 1'b1);
        for (int k = 0; k < 200; k++) step(8'h00, 1'b0);
        chk("nto_still_busy", 32'(busy), 32'd1);
        step(8'h00, 1'b1);
        chk("nto_busy_after", 32'(busy), 32'd0);
        chk("nto_err", 32'(err_cnt), 32'd0);
`endif

        // Arbitration with backpressure: slaves 2 and 9, one byte each
        base = got_b.size();
        smem[2][0] = 8'hC3; slen[2] = 8'd1;
        smem[9][0] = 8'h9D; slen[9] = 8'd1;
        ld = (N'(1) << 2) | (N'(1) << 9);
        @(posedge clk); #1;
        ld = '0;
        for (int k = 0; k < 400 && got_b.size() < base + 8; k++) begin
            tx_ready = ~tx_ready;
            @(posedge clk); #1;
        end
        tx_ready = 1'b0;
        eb = '{8'h5A, 8'h02, 8'h01, 8'hC3, 8'h5A, 8'h09, 8'h01, 8'h9D};
        er = '{'0, '0, '0, N'(1) << 2, '0, '0, '0, N'(1) << 9};
        tx_expect("arb", base, eb, er);

        // Zero-length reply, then a 2-byte reply to slave 26 while it is being written
        base = got_b.size();
        fork
            begin
                slen[0] = 8'd0;
                smem[26][0] = 8'h01; smem[26][1] = 8'h02; slen[26] = 8'd2;
                ld = N'(1) | (N'(1) << 26);
                @(posedge clk); #1;
                ld = '0;
                for (int k = 0; k < 400 && got_b.size() < base + 8; k++) begin
                    tx_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                tx_ready = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                step(8'hA5, 1'b1);
                step(8'h1A, 1'b1);
                step(8'h01, 1'b1);
                step(8'h55, 1'b1);
                chk("conc_vb", 32'(valid_bus), 32'(N'(1) << 26));
                chk("conc_md", 32'(master_data), 32'h55);
                step(8'h00, 1'b0);
                chk("conc_vb_clear", 32'(valid_bus), 32'd0);
            end
        join
        eb = '{8'h5A, 8'h00, 8'h00, 8'h5A, 8'h1A, 8'h02, 8'h01, 8'h02};
        er = '{'0, '0, N'(1), '0, '0, '0, N'(1) << 26, N'(1) << 26};
        tx_expect("zlen", base, eb, er);

        repeat (4) @(posedge clk);
        #1;
        chk("tx_idle_busy", 32'(busy), 32'd0);
        chk("tx_idle_valid", 32'(tx_valid), 32'd0);
        chk("slaves_drained", 32'(spend), 32'd0);
        chk("stray_rdreq", 32'(stray), 32'd0);
        chk("stall_stable", 32'(stall_err), 32'd0);
        chk("one_hot", 32'(multi), 32'd0);

        // err_cnt saturation with bad-address, zero-length frames
        for (int k = 0; k < 255; k++) begin
            step(8'hA5, 1'b1);
            step(8'hFF, 1'b1);
            step(8'h00, 1'b1);
        end
        chk("err_sat", 32'(err_cnt), 32'hFF);
        step(8'hA5, 1'b1);
        step(8'hFF, 1'b1);
        step(8'h00, 1'b1);
        chk("err_sat_hold", 32'(err_cnt), 32'hFF);
        chk("err_sat_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
